alu_muldiv_unit: RTL and testbench

- Parametrised, handshaked execute unit; next generation of the single-cycle RV32I ALU.
- Executes all base integer ALU ops with one-cycle registered latency.
- Adds the RV32M multiply/divide ops (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) on an iterative radix-2 datapath.
- Sits in the EX stage; the pipeline stalls on in_ready=0 and consumes results via out_valid/out_ready.

---
 rtl/alu_pkg.sv | 61 ++++++
 rtl/alu_base_core.sv | 37 +++
 rtl/alu_muldiv_unit.sv | 176 +++++++++++++++++
 tb/tb_alu_muldiv_unit.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU / multiply-divide execute unit:
// op encodings, FSM state type and op-class helpers.
package alu_pkg;

    // Base op encodings (op[4]=0, these are op[3:0])
    localparam logic [3:0] ALU_ADD    = 4'b0000;
    localparam logic [3:0] ALU_SUB    = 4'b0001;
    localparam logic [3:0] ALU_AND    = 4'b0100;
    localparam logic [3:0] ALU_OR     = 4'b0101;
    localparam logic [3:0] ALU_XOR    = 4'b0110;
    localparam logic [3:0] ALU_PASS_A = 4'b0111;
    localparam logic [3:0] ALU_SHL    = 4'b1000;
    localparam logic [3:0] ALU_SHR    = 4'b1010;
    localparam logic [3:0] ALU_SHA    = 4'b1011;
    localparam logic [3:0] ALU_SLT    = 4'b1100;
    localparam logic [3:0] ALU_SLTU   = 4'b1101;
    localparam logic [3:0] ALU_PASS_B = 4'b1111;

    // M op encodings (op[4]=1, these are op[2:0])
    localparam logic [2:0] MD_MUL    = 3'b000;
    localparam logic [2:0] MD_MULH   = 3'b001;
    localparam logic [2:0] MD_MULHSU = 3'b010;
    localparam logic [2:0] MD_MULHU  = 3'b011;
    localparam logic [2:0] MD_DIV    = 3'b100;
    localparam logic [2:0] MD_DIVU   = 3'b101;
    localparam logic [2:0] MD_REM    = 3'b110;
    localparam logic [2:0] MD_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MUL  = 2'b01,
        DIV  = 2'b10,
        DONE = 2'b11
    } state_t;

    function automatic logic is_mul(input logic [4:0] op);
        return op[4] && !op[2];
    endfunction

    function automatic logic is_div(input logic [4:0] op);
        return op[4] && op[2];
    endfunction

    // Remainder ops return the remainder half of the shared register
    function automatic logic is_rem(input logic [4:0] op);
        return op[4] && op[2] && op[1];
    endfunction

    // MUL is treated as signed; its low half is identical either way
    function automatic logic is_signed_a(input logic [4:0] op);
        return op[4] && (op[2:0] == MD_MUL  || op[2:0] == MD_MULH ||
                         op[2:0] == MD_MULHSU || op[2:0] == MD_DIV ||
                         op[2:0] == MD_REM);
    endfunction

    function automatic logic is_signed_b(input logic [4:0] op);
        return op[4] && (op[2:0] == MD_MUL || op[2:0] == MD_MULH ||
                         op[2:0] == MD_DIV || op[2:0] == MD_REM);
    endfunction

endpackage

// File: rtl/alu_base_core.sv
// Combinational datapath for the base integer ops; the top registers its output.
module alu_base_core #(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic [WIDTH-1:0] y
);
    import alu_pkg::*;

    localparam int SHAMT_W = $clog2(WIDTH);

    logic [SHAMT_W-1:0] shamt;
    assign shamt = src_b[SHAMT_W-1:0];

    // Select the base-op result; undefined encodings yield zero
    always_comb begin
        y = '0;
        case (op)
            ALU_ADD:    y = src_a + src_b;
            ALU_SUB:    y = src_a - src_b;
            ALU_AND:    y = src_a & src_b;
            ALU_OR:     y = src_a | src_b;
            ALU_XOR:    y = src_a ^ src_b;
            ALU_PASS_A: y = src_a;
            ALU_SHL:    y = src_a << shamt;
            ALU_SHR:    y = src_a >> shamt;
            ALU_SHA:    y = WIDTH'($signed(src_a) >>> shamt);
            ALU_SLT:    y = {{(WIDTH-1){1'b0}}, $signed(src_a) < $signed(src_b)};
            ALU_SLTU:   y = {{(WIDTH-1){1'b0}}, src_a < src_b};
            ALU_PASS_B: y = src_b;
            default:    y = '0;
        endcase
    end

endmodule

// File: rtl/alu_muldiv_unit.sv
// Handshaked EX-stage unit: single-cycle base ALU ops plus iterative
// radix-2 multiply/divide sharing one double-width product/remainder register.
module alu_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero
);
    import alu_pkg::*;

    localparam int               CNT_W    = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};

    state_t             state_q, state_d;
    logic [2:0]         md_op_q, md_op_d;
    logic               neg_q, neg_d;
    logic [WIDTH-1:0]   divisor_q, divisor_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               zero_q, zero_d;

    logic [WIDTH-1:0]   base_y;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next, mul_fix;
    logic [WIDTH:0]     div_trial;
    logic [WIDTH-1:0]   div_rem;
    logic [2*WIDTH-1:0] div_next;
    logic [WIDTH-1:0]   div_quo_fix, div_rem_fix;
    logic               load_res;
    logic [WIDTH-1:0]   res_val;

    alu_base_core #(.WIDTH(WIDTH)) u_base (
        .op    (op[3:0]),
        .src_a (src_a),
        .src_b (src_b),
        .y     (base_y)
    );

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign zero      = zero_q;

    // Operand magnitudes and one shift-add / restoring-divide step
    always_comb begin
        a_neg = is_signed_a(op) && src_a[WIDTH-1];
        b_neg = is_signed_b(op) && src_b[WIDTH-1];
        mag_a = a_neg ? -src_a : src_a;
        mag_b = b_neg ? -src_b : src_b;

        mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, (prod_q[0] ? divisor_q : {WIDTH{1'b0}})};
        mul_next = {mul_sum, prod_q[WIDTH-1:1]};
        mul_fix  = neg_q ? -mul_next : mul_next;

        div_trial = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]} - {1'b0, divisor_q};
        div_rem   = div_trial[WIDTH] ? prod_q[2*WIDTH-2:WIDTH-1] : div_trial[WIDTH-1:0];
        div_next  = {div_rem, prod_q[WIDTH-2:0], ~div_trial[WIDTH]};
        div_quo_fix = neg_q ? -div_next[WIDTH-1:0] : div_next[WIDTH-1:0];
        div_rem_fix = neg_q ? -div_next[2*WIDTH-1:WIDTH] : div_next[2*WIDTH-1:WIDTH];
    end

    // Next-state and datapath-load decisions; flush wins over everything
    always_comb begin
        state_d   = state_q;
        md_op_d   = md_op_q;
        neg_d     = neg_q;
        divisor_d = divisor_q;
        prod_d    = prod_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        zero_d    = zero_q;
        load_res  = 1'b0;
        res_val   = '0;

        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        md_op_d   = op[2:0];
                        neg_d     = is_rem(op) ? a_neg : (a_neg ^ b_neg);
                        divisor_d = mag_b;
                        prod_d    = {{WIDTH{1'b0}}, mag_a};
                        cnt_d     = CNT_LOAD;
                        if (!op[4]) begin
                            load_res = 1'b1;
                            res_val  = base_y;
                            state_d  = DONE;
                        end else if (is_mul(op)) begin
                            state_d = MUL;
                        end else if (src_b == '0) begin
                            load_res = 1'b1;
                            res_val  = is_rem(op) ? src_a : '1;
                            state_d  = DONE;
                        end else if (is_signed_a(op) && src_a == MIN_VAL && src_b == '1) begin
                            load_res = 1'b1;
                            res_val  = is_rem(op) ? '0 : MIN_VAL;
                            state_d  = DONE;
                        end else begin
                            state_d = DIV;
                        end
                    end
                end
                MUL: begin
                    prod_d = mul_next;
                    cnt_d  = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        load_res = 1'b1;
                        res_val  = (md_op_q == MD_MUL) ? mul_fix[WIDTH-1:0] : mul_fix[2*WIDTH-1:WIDTH];
                        state_d  = DONE;
                    end
                end
                DIV: begin
                    prod_d = div_next;
                    cnt_d  = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        load_res = 1'b1;
                        res_val  = md_op_q[1] ? div_rem_fix : div_quo_fix;
                        state_d  = DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (load_res) begin
            result_d = res_val;
            zero_d   = (res_val == '0);
        end
    end

    // State and datapath registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            md_op_q   <= '0;
            neg_q     <= 1'b0;
            divisor_q <= '0;
            prod_q    <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
            zero_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            md_op_q   <= md_op_d;
            neg_q     <= neg_d;
            divisor_q <= divisor_d;
            prod_q    <= prod_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
        end
    end

endmodule

// File: tb/tb_alu_muldiv_unit.sv
// Directed self-checking bench for alu_muldiv_unit at WIDTH=32.
module tb_alu_muldiv_unit;

    localparam int WIDTH = 32;

    localparam logic [4:0] OP_ADD    = 5'b00000;
    localparam logic [4:0] OP_SUB    = 5'b00001;
    localparam logic [4:0] OP_UNDEF  = 5'b00010;
    localparam logic [4:0] OP_XOR    = 5'b00110;
    localparam logic [4:0] OP_SHL    = 5'b01000;
    localparam logic [4:0] OP_SHR    = 5'b01010;
    localparam logic [4:0] OP_SHA    = 5'b01011;
    localparam logic [4:0] OP_SLT    = 5'b01100;
    localparam logic [4:0] OP_SLTU   = 5'b01101;
    localparam logic [4:0] OP_PASSB  = 5'b01111;
    localparam logic [4:0] OP_MUL    = 5'b10000;
    localparam logic [4:0] OP_MULH   = 5'b10001;
    localparam logic [4:0] OP_MULHSU = 5'b10010;
    localparam logic [4:0] OP_MULHU  = 5'b10011;
    localparam logic [4:0] OP_DIV    = 5'b10100;
    localparam logic [4:0] OP_DIVU   = 5'b10101;
    localparam logic [4:0] OP_REM    = 5'b10110;
    localparam logic [4:0] OP_REMU   = 5'b10111;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [4:0]       op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;

    int checks   = 0;
    int failures = 0;
    int lat;
    int busy_seen;
    int valid_seen;

    alu_muldiv_unit #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .src_a     (src_a),
        .src_b     (src_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    // Present one op for a single accept edge, then scramble the inputs
    task automatic applyStimulus(input logic [4:0] o, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        op       = o;
        src_a    = a;
        src_b    = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        op       = OP_PASSB;
        src_a    = 32'hDEADBEEF;
        src_b    = 32'h12345678;
    endtask

    // Count cycles after the accept edge until out_valid, bounded by limit
    task automatic waitResult(input int limit);
        lat       = 1;
        busy_seen = 0;
        if (in_ready) busy_seen++;
        while (!out_valid && lat < limit) begin
            tick();
            lat++;
            if (in_ready) busy_seen++;
        end
    endtask

    task automatic runOp(input string tag, input logic [4:0] o, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] exp_res, input int exp_lat);
        applyStimulus(o, a, b);
        waitResult(exp_lat + 5);
        checkOutput({tag, " out_valid"}, WIDTH'(out_valid), 32'd1);
        checkOutput({tag, " latency"}, WIDTH'(lat), WIDTH'(exp_lat));
        checkOutput({tag, " result"}, result, exp_res);
        checkOutput({tag, " zero"}, WIDTH'(zero), WIDTH'(exp_res == '0));
        checkOutput({tag, " busy"}, WIDTH'(busy_seen), 32'd0);
        tick();
        checkOutput({tag, " idle"}, WIDTH'({in_ready, out_valid}), 32'd2);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        op        = OP_ADD;
        src_a     = '0;
        src_b     = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        checkOutput("reset out_valid", WIDTH'(out_valid), 32'd0);
        checkOutput("reset result", result, 32'd0);
        checkOutput("reset zero", WIDTH'(zero), 32'd0);
        checkOutput("reset in_ready", WIDTH'(in_ready), 32'd1);
        tick();

        // Base ops
        runOp("ADD ovf",   OP_ADD,   32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1);
        runOp("SUB zero",  OP_SUB,   32'd5,        32'd5,        32'h00000000, 1);
        runOp("SHA",       OP_SHA,   32'h80000000, 32'h00000024, 32'hF8000000, 1);
        runOp("SLT",       OP_SLT,   32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1);
        runOp("SLTU",      OP_SLTU,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1);
        runOp("XOR",       OP_XOR,   32'h0F0F0F0F, 32'h00FF00FF, 32'h0FF00FF0, 1);
        runOp("SHL",       OP_SHL,   32'h00000001, 32'h0000003F, 32'h80000000, 1);
        runOp("SHR",       OP_SHR,   32'h80000000, 32'h00000004, 32'h08000000, 1);
        runOp("UNDEF",     OP_UNDEF, 32'h00000005, 32'h00000003, 32'h00000000, 1);

        // Multiply
        runOp("MULH",      OP_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33);
        runOp("MULHU",     OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
        runOp("MUL",       OP_MUL,    32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 33);
        runOp("MULHSU",    OP_MULHSU, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 33);

        // Divide, including fast paths
        runOp("DIV",       OP_DIV,  32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 33);
        runOp("REM",       OP_REM,  32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 33);
        runOp("DIVU",      OP_DIVU, 32'd100,      32'd7,        32'd14,       33);
        runOp("REMU",      OP_REMU, 32'd100,      32'd7,        32'd2,        33);
        runOp("DIVU by0",  OP_DIVU, 32'd100,      32'd0,        32'hFFFFFFFF, 1);
        runOp("REMU by0",  OP_REMU, 32'd100,      32'd0,        32'd100,      1);
        runOp("REM ovf",   OP_REM,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1);
        runOp("DIV ovf",   OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);

        // Backpressure: result must hold while out_ready is low
        out_ready = 1'b0;
        applyStimulus(OP_MUL, 32'h00000007, 32'hFFFFFFFD);
        waitResult(40);
        checkOutput("bp latency", WIDTH'(lat), 32'd33);
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("bp out_valid", WIDTH'(out_valid), 32'd1);
            checkOutput("bp result", result, 32'hFFFFFFEB);
            checkOutput("bp zero", WIDTH'(zero), 32'd0);
            checkOutput("bp in_ready", WIDTH'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        checkOutput("bp release", WIDTH'({in_ready, out_valid}), 32'd2);
        runOp("ADD after bp", OP_ADD, 32'd1, 32'd2, 32'd3, 1);

        // Flush in IDLE must not accept the op
        op       = OP_ADD;
        src_a    = 32'd1;
        src_b    = 32'd1;
        in_valid = 1'b1;
        flush    = 1'b1;
        tick();
        in_valid = 1'b0;
        flush    = 1'b0;
        checkOutput("flush idle out_valid", WIDTH'(out_valid), 32'd0);
        checkOutput("flush idle in_ready", WIDTH'(in_ready), 32'd1);

        // Flush mid-DIVU discards the op
        applyStimulus(OP_DIVU, 32'd100, 32'd7);
        repeat (9) tick();
        checkOutput("flush busy", WIDTH'(in_ready), 32'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checkOutput("flush to idle", WIDTH'({in_ready, out_valid}), 32'd2);
        valid_seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (out_valid) valid_seen++;
        end
        checkOutput("flush no result", WIDTH'(valid_seen), 32'd0);
        checkOutput("flush keeps result", result, 32'd3);

        // Asynchronous reset mid-MUL
        applyStimulus(OP_MUL, 32'd7, 32'd3);
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        checkOutput("async rst out_valid", WIDTH'(out_valid), 32'd0);
        checkOutput("async rst result", result, 32'd0);
        checkOutput("async rst zero", WIDTH'(zero), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        checkOutput("post rst in_ready", WIDTH'(in_ready), 32'd1);
        runOp("SUB after rst", OP_SUB, 32'd10, 32'd3, 32'd7, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
